// File: rtl/display_mux_n.sv
// Multiplexed seven-segment scanner: N_DIGITS hex digits, per-digit blank and
// decimal point, 8-level PWM brightness, frame-synchronous content snapshot.
module display_mux_n #(
    parameter int N_DIGITS = 6,
    parameter int DIV_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [2:0]            bright,
    output logic [0:6]            sseg,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an,
    output logic                  led,
    output logic                  frame_tick
);

    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [DIV_LOG2-1:0] SLOT_LAST  = '1;
    localparam logic [DW-1:0]       DIGIT_LAST = DW'(N_DIGITS - 1);

    logic [DIV_LOG2-1:0]   slotCnt;
    logic [DW-1:0]         digitIdx;
    logic [4*N_DIGITS-1:0] dataSnap;
    logic [N_DIGITS-1:0]   blankSnap;
    logic [N_DIGITS-1:0]   dpSnap;
    logic                  frameSeen;

    logic                  slotEnd;
    logic                  frameEnd;
    logic [3:0]            curNibble;
    logic                  curBlank;
    logic                  curDp;
    logic                  digitOn;
    logic [6:0]            segCode;
    logic [N_DIGITS-1:0]   anNext;
    logic                  startTick;

    // Hex to active-low segments, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] segDecode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign slotEnd  = (slotCnt == SLOT_LAST);
    assign frameEnd = slotEnd && (digitIdx == DIGIT_LAST);

    // Slot counter and digit index; digit wraps explicitly so non-power-of-2
    // digit counts never reach an unused index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slotCnt  <= '0;
            digitIdx <= '0;
        end else begin
            slotCnt <= slotCnt + 1'b1;
            if (slotEnd)
                digitIdx <= frameEnd ? '0 : digitIdx + 1'b1;
        end
    end

    // Frame snapshot of displayed content, taken on the wrap to digit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataSnap  <= '0;
            blankSnap <= '0;
            dpSnap    <= '0;
            frameSeen <= 1'b0;
        end else if (frameEnd) begin
            dataSnap  <= data;
            blankSnap <= blank;
            dpSnap    <= dp;
            frameSeen <= 1'b1;
        end
    end

    // Select the current digit's snapshot fields and form the anode pattern.
    always_comb begin
        curNibble = '0;
        curBlank  = 1'b0;
        curDp     = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (digitIdx == DW'(i)) begin
                curNibble = dataSnap[i*4 +: 4];
                curBlank  = blankSnap[i];
                curDp     = dpSnap[i];
            end
        end
        digitOn = !curBlank && (slotCnt[DIV_LOG2-1 -: 3] <= bright);
        segCode = segDecode(curNibble);
        anNext  = '1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (digitOn && (digitIdx == DW'(i)))
                anNext[i] = 1'b0;
        end
        startTick = frameSeen && (slotCnt == '0) && (digitIdx == '0);
    end

    // Registered pin drivers; segments stay dark whenever no anode is enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an         <= '1;
            sseg       <= 7'b1111111;
            dp_n       <= 1'b1;
            led        <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            an         <= anNext;
            sseg       <= digitOn ? segCode : 7'b1111111;
            dp_n       <= !(digitOn && curDp);
            frame_tick <= startTick;
            led        <= led ^ startTick;
        end
    end

endmodule

// File: tb/tb_display_mux_n.sv
// Scoreboard bench for display_mux_n with N_DIGITS=6, DIV_LOG2=3.
`timescale 1ns/100ps
module tb_display_mux_n;

    localparam int ND    = 6;
    localparam int SLOT  = 8;
    localparam int FRAME = ND * SLOT;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*ND-1:0] data;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   dp;
    logic [2:0]      bright;
    logic [0:6]      sseg;
    logic            dp_n;
    logic [ND-1:0]   an;
    logic            led;
    logic            frame_tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0]    sseg;
        logic          dpn;
        logic [ND-1:0] an;
        logic          led;
        logic          tick;
    } exp_t;

    exp_t sb[$];

    logic [6:0] decTab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model state: t = clock edges since reset release.
    int unsigned     t = 0;
    logic [4*ND-1:0] snapData  = '0;
    logic [ND-1:0]   snapBlank = '0;
    logic [ND-1:0]   snapDp    = '0;

    display_mux_n #(.N_DIGITS(ND), .DIV_LOG2(3)) dut (
        .clk(clk), .rst(rst), .data(data), .blank(blank), .dp(dp),
        .bright(bright), .sseg(sseg), .dp_n(dp_n), .an(an), .led(led),
        .frame_tick(frame_tick)
    );

    always #1 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Predict the outputs each edge produces and queue them.
    always @(posedge clk) begin
        exp_t e;
        int unsigned d, s;
        logic en;
        if (!rst) begin
            e.sseg = 7'b1111111; e.dpn = 1'b1; e.an = '1; e.led = 1'b0; e.tick = 1'b0;
            t         <= 0;
            snapData  <= '0;
            snapBlank <= '0;
            snapDp    <= '0;
        end else begin
            d  = (t / SLOT) % ND;
            s  = t % SLOT;
            en = !snapBlank[d] && (s <= bright);
            e.an   = en ? ~(6'b000001 << d) : 6'b111111;
            e.sseg = en ? decTab[snapData[d*4 +: 4]] : 7'b1111111;
            e.dpn  = en ? !snapDp[d] : 1'b1;
            e.tick = (t % FRAME == 0) && (t > 0);
            e.led  = ((t / FRAME) % 2) == 1;
            if (t % FRAME == FRAME - 1) begin
                snapData  <= data;
                snapBlank <= blank;
                snapDp    <= dp;
            end
            t <= t + 1;
        end
        sb.push_back(e);
    end

    // Compare DUT outputs shortly after each edge against the queued prediction.
    always begin
        exp_t e;
        @(posedge clk);
        #0.25;
        if (sb.size() == 0) begin
            chk("sbEmpty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("sseg", 32'(sseg), 32'(e.sseg));
            chk("dp_n", 32'(dp_n), 32'(e.dpn));
            chk("an", 32'(an), 32'(e.an));
            chk("led", 32'(led), 32'(e.led));
            chk("frame_tick", 32'(frame_tick), 32'(e.tick));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #0.5;
    endtask

    // Count cycles with any anode enabled over one full frame.
    task automatic dutyCheck(input string tag, input int expLow);
        int low = 0;
        repeat (FRAME) begin
            @(posedge clk);
            #0.25;
            if (an != '1) low++;
        end
        #0.25;
        chk(tag, 32'(low), 32'(expLow));
    endtask

    initial begin
        bool_found: begin end
    end

    initial begin
        bit found;
        rst    = 1'b0;
        data   = 24'h000F37;
        blank  = '0;
        dp     = '0;
        bright = 3'd7;
        #200;
        chk("rstAn", 32'(an), 32'h3F);
        chk("rstSseg", 32'(sseg), 32'h7F);
        #50;
        rst = 1'b1;

        // Mid-first-frame data change must wait for the wrap.
        cycles(20);
        data = 24'h0000F3;
        cycles(FRAME * 2);

        // Blanking and decimal point.
        blank = 6'b000100;
        dp    = 6'b000001;
        cycles(FRAME * 2);

        // Brightness levels: five lit digits, (bright+1) cycles per slot.
        bright = 3'd0;
        cycles(FRAME);
        dutyCheck("duty0", 5 * 1);
        bright = 3'd3;
        cycles(FRAME);
        dutyCheck("duty3", 5 * 4);
        bright = 3'd7;
        cycles(FRAME);
        dutyCheck("duty7", 5 * 8);

        // Async reset at digit 3, slot 5 of a frame where led is high.
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            cycles(1);
            if ((t % FRAME == 29) && ((t / FRAME) % 2 == 1)) found = 1'b1;
        end
        chk("midWait", 32'(found), 32'd1);
        chk("preRstLed", 32'(led), 32'd1);
        rst = 1'b0;
        #0.1;
        chk("midRstAn", 32'(an), 32'h3F);
        chk("midRstLed", 32'(led), 32'd0);
        chk("midRstSseg", 32'(sseg), 32'h7F);
        cycles(3);
        rst = 1'b1;
        cycles(FRAME + 4);

        // Decode sweep on digit 0.
        blank = '0;
        dp    = '0;
        for (int v = 0; v < 16; v++) begin
            data = 24'(v);
            cycles(FRAME);
        end
        cycles(FRAME + 2);

        #0.2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_mux_n.md
Name: display_mux_n

Overview:
- Parametrised multiplexed seven-segment driver, successor to the fixed 6-digit register-file display.
- Scans N_DIGITS hex digits from a flat data vector.
- Adds per-digit blanking, decimal points, 8-level brightness (PWM within each digit slot), tear-free frame snapshot, and frame pulse/LED outputs.
- Sits between the register-file/datapath outputs and the board's common-anode display pins.

Parameters:
- N_DIGITS, 6: number of digits scanned, 2..8.
- DIV_LOG2, 10: log2 of clock cycles per digit slot; must be >=3. DIV = 2**DIV_LOG2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- data  in  4*N_DIGITS  hex nibbles; digit i = data[4i+3:4i].
- blank  in  N_DIGITS  1 = digit i dark.
- dp  in  N_DIGITS  1 = decimal point of digit i lit.
- bright  in  3  brightness level 0..7.
- sseg  out  [0:6]  segments a..g, active-low.
- dp_n  out  1  decimal point, active-low.
- an  out  N_DIGITS  anode enables, active-low, one-hot-low or all-high.
- led  out  1  toggles once per completed frame.
- frame_tick  out  1  one-cycle pulse at frame start.

Behaviour:
- Reset (rst=0, async):
  - slot_cnt=0, digit=0, snapshot=0.
  - an=all 1, sseg=7'b1111111, dp_n=1, led=0, frame_tick=0.
- Counters:
  - slot_cnt (DIV_LOG2 bits) increments every clk.
  - On slot_cnt==DIV-1, slot_cnt wraps to 0 and digit advances.
  - Digit wraps N_DIGITS-1 -> 0; no out-of-range index is ever reached.
  - Frame = N_DIGITS*DIV cycles.
- Snapshot:
  - data, blank and dp are captured into internal registers on the edge where digit wraps N_DIGITS-1 -> 0.
  - Display content is constant within a frame; input changes mid-frame appear only in the next frame.
  - First frame after reset shows "0" on every digit, no dp, no blanking.
- bright is not snapshotted; it takes effect immediately.
- Outputs are registered, one-cycle latency behind counter state.
  - The first edge after rst rises drives digit 0, slot 0.
- Anode enable for the current digit d (registered next cycle): en = !blank_s[d] && (slot_cnt[DIV_LOG2-1:DIV_LOG2-3] <= bright).
  - bright=7: 100% duty.
  - bright=0: 1/8 duty (first DIV/8 cycles of each slot).
- en=1:
  - an[d]=0, all other an bits 1.
  - sseg = decode(snapshot nibble d).
  - dp_n = !dp_s[d].
- en=0:
  - an = all 1, sseg = 1111111, dp_n = 1.
  - Segments are never driven while all anodes are off (anti-ghosting).
- Decode, active-low, order a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- frame_tick and led:
  - frame_tick=1 for exactly the one cycle in which the outputs show digit 0, slot 0 of a new frame (excluding the first frame after reset).
  - led toggles on that same edge.
- Reset mid-frame: all state returns to reset values immediately; snapshot is cleared.

Test Plan:
- N_DIGITS=6, DIV_LOG2=3 (DIV=8, frame=48 cycles), clk period 2.
- Reset/first frame: hold rst=0 for 250 time units, data=0x000F37, release -> an stays all-1 during reset. First frame shows sseg=0000001 on each digit in order: an=111110 for 8 cycles, then 111101, and so on. frame_tick=0 and led=0 until cycle 48.
- Snapshot: set data={...,4'hF,4'h3} (digit1=F, digit0=3) mid-first-frame -> unchanged until the wrap. Frame 2: digit0 sseg=0000110, digit1 sseg=0111000. frame_tick is a single pulse and led=1.
- Blank and dp: blank=6'b000100, dp=6'b000001 -> digit2 slot has an=all-1 and sseg=1111111 for all 8 cycles. Digit0 has dp_n=0; all other digits have dp_n=1.
- Brightness:
  - bright=0 -> each digit's anode is low for exactly 1 of 8 slot cycles.
  - bright=3 -> low for 4 of 8.
  - bright=7 -> low for 8 of 8.
  - sseg=1111111 whenever an is all-1.
- Mid-frame reset: assert rst=0 at digit 3, slot 5 -> an all-1 and led=0 immediately. After release, the scan restarts at digit 0 and the display shows zeros (snapshot cleared).
- Decode sweep: cycle data through all 16 nibble values on digit 0 across 16 frames -> sseg matches the decode list for every value.
